// File: rtl/fb_address.sv
// Framebuffer address generator: addr = y * FB_WIDTH + x, row-major. Optional FB_ADDR_CLAMP_EN saturates x/y.
// Latency: one clock, registered output, one coordinate per clock.
// Backpressure: none; x/y are sampled on every rising edge.
module fb_address #(
  parameter  int FB_WIDTH  = 640,
  parameter  int FB_HEIGHT = 480,
  parameter  int ADDR_BITS = 20,
  localparam int FB_X_BITS = $clog2(FB_WIDTH),
  localparam int FB_Y_BITS = $clog2(FB_HEIGHT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [FB_X_BITS-1:0] x,
  input  logic [FB_Y_BITS-1:0] y,
  output logic [ADDR_BITS-1:0] addr
);

  if (FB_WIDTH <= 1) begin : g_bad_width
    $fatal(1, "fb_address: FB_WIDTH must be greater than 1");
  end
  if (FB_HEIGHT <= 1) begin : g_bad_height
    $fatal(1, "fb_address: FB_HEIGHT must be greater than 1");
  end
  if (ADDR_BITS < $clog2(FB_WIDTH * FB_HEIGHT)) begin : g_bad_addr
    $fatal(1, "fb_address: ADDR_BITS too narrow for FB_WIDTH*FB_HEIGHT");
  end

  localparam logic [FB_X_BITS-1:0] X_MAX  = FB_X_BITS'(FB_WIDTH - 1);
  localparam logic [FB_Y_BITS-1:0] Y_MAX  = FB_Y_BITS'(FB_HEIGHT - 1);
  localparam logic [ADDR_BITS-1:0] STRIDE = ADDR_BITS'(FB_WIDTH);

  logic [FB_X_BITS-1:0] x_eff;
  logic [FB_Y_BITS-1:0] y_eff;
  logic [ADDR_BITS-1:0] addr_nxt;

`ifdef FB_ADDR_CLAMP_EN
  // Saturate before the multiply-add so the result stays inside the frame.
  always_comb begin
    x_eff = (x > X_MAX) ? X_MAX : x;
    y_eff = (y > Y_MAX) ? Y_MAX : y;
  end
`else
  // Out-of-range coordinates pass through; the sum wraps at ADDR_BITS.
  always_comb begin
    x_eff = x;
    y_eff = y;
  end
`endif

  always_comb begin
    addr_nxt = ADDR_BITS'(y_eff) * STRIDE + ADDR_BITS'(x_eff);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else begin
      addr <= addr_nxt;
    end
  end

endmodule

// File: tb/tb_fb_address.sv
// Randomized bench for fb_address: per-cycle model comparison plus directed literal checks.
module tb_fb_address;

  localparam int W  = 640;
  localparam int H  = 480;
  localparam int AB = 20;
  localparam int XB = $clog2(W);
  localparam int YB = $clog2(H);

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [XB-1:0] x     = '0;
  logic [YB-1:0] y     = '0;
  logic [AB-1:0] addr;

  int errors = 0;
  int checks = 0;

  fb_address #(.FB_WIDTH(W), .FB_HEIGHT(H), .ADDR_BITS(AB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (x),
    .y     (y),
    .addr  (addr)
  );

  always #5 clk = ~clk;

  // Row-major address from plain integer arithmetic.
  function automatic longint unsigned model(input longint unsigned xv, input longint unsigned yv);
    longint unsigned xe, ye;
    xe = xv;
    ye = yv;
`ifdef FB_ADDR_CLAMP_EN
    if (xe > W - 1) xe = W - 1;
    if (ye > H - 1) ye = H - 1;
`endif
    return (ye * W + xe) % (64'd1 << AB);
  endfunction

  task automatic chk(input string name, input longint unsigned got, input longint unsigned want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: addr=%0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Expected value tracks the reset and the coordinate held at each edge.
  longint unsigned exp_addr = 0;
  bit              exp_vld  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_addr = 0;
      exp_vld  = 1'b1;
    end else begin
      exp_addr = model(longint'(x), longint'(y));
    end
  end

  always @(negedge clk) begin
    if (exp_vld) chk("model", longint'(addr), exp_addr);
  end

  task automatic drive(input int xv, input int yv);
    @(posedge clk);
    #2;
    x = XB'(xv);
    y = YB'(yv);
  endtask

  task automatic drive_chk(input string name, input int xv, input int yv, input int want);
    drive(xv, yv);
    @(posedge clk);
    #1;
    chk(name, longint'(addr), longint'(want));
  endtask

  initial begin
    // Reset asserted with no clock edge yet.
    x = XB'(5);
    y = YB'(5);
    #1 rst_n = 1'b0;
    #2 chk("reset_async", longint'(addr), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    x = '0;
    y = '0;
    @(posedge clk);
    #1 chk("origin", longint'(addr), 0);

    drive_chk("x1", 1, 0, 1);
    drive_chk("y1", 0, 1, 640);
    drive_chk("x1y1", 1, 1, 641);
    drive_chk("corner_tr", 639, 0, 639);
    drive_chk("corner_bl", 0, 479, 306560);
    drive_chk("corner_br", 639, 479, 307199);

    // Back-to-back stream, one result per clock.
    drive(2, 3);
    @(posedge clk);
    #1 chk("stream0", longint'(addr), 1922);
    #1 begin x = XB'(4); y = YB'(5); end
    @(posedge clk);
    #1 chk("stream1", longint'(addr), 3204);
    #1 begin x = XB'(6); y = YB'(7); end
    @(posedge clk);
    #1 chk("stream2", longint'(addr), 4486);

    // Mid-stream reset pulse between edges.
    drive_chk("pre_reset", 1, 1, 641);
    #1 rst_n = 1'b0;
    #1 chk("reset_mid", longint'(addr), 0);
    #2 rst_n = 1'b1;
    x = XB'(2);
    y = YB'(3);
    @(posedge clk);
    #1 chk("post_reset", longint'(addr), 1922);

`ifdef FB_ADDR_CLAMP_EN
    drive_chk("out_of_range", 700, 500, 307199);
`else
    drive_chk("out_of_range", 700, 500, 320700);
`endif

    // Random coordinates, half in range, with occasional reset pulses.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #2;
      if ($urandom_range(0, 1) == 0) begin
        x = XB'($urandom_range(0, W - 1));
        y = YB'($urandom_range(0, H - 1));
      end else begin
        x = XB'($urandom_range(0, (1 << XB) - 1));
        y = YB'($urandom_range(0, (1 << YB) - 1));
      end
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
